// File: rtl/video_pattern_gen_pkg.sv
// Shared types and helpers for the video test-pattern source: pattern codes,
// FSM states and the colour-bar table.
package video_pattern_gen_pkg;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_GRAD  = 2'd1,
        PAT_SOLID = 2'd2,
        PAT_CHECK = 2'd3
    } pattern_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Bar colour as {b, g, r} on/off flags; each flag expands to a full component.
    function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
        logic [2:0] rgb;
        case (idx)
            3'd0:    rgb = 3'b111;  // white
            3'd1:    rgb = 3'b011;  // yellow
            3'd2:    rgb = 3'b110;  // cyan
            3'd3:    rgb = 3'b010;  // green
            3'd4:    rgb = 3'b101;  // magenta
            3'd5:    rgb = 3'b001;  // red
            3'd6:    rgb = 3'b100;  // blue
            3'd7:    rgb = 3'b000;  // black
            default: rgb = 3'b000;
        endcase
        return rgb;
    endfunction

    function automatic logic [2:0] bar_next(input logic [2:0] idx);
        logic [2:0] nxt;
        if (idx == 3'd7) begin
            nxt = 3'd7;
        end else begin
            nxt = idx + 3'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/video_timing_counter.sv
// Raster timing core: per-frame shadow registers, h/v counters, IDLE/RUN FSM
// and the raw (unregistered) de/hs/vs/sof strobes.
module video_timing_counter
    import video_pattern_gen_pkg::*;
#(
    parameter int PIXEL_WIDTH = 8,
    parameter int TW          = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en_i,
    input  logic [1:0]               pattern_i,
    input  logic [3*PIXEL_WIDTH-1:0] solid_i,
    input  logic [TW-1:0]            h_active_i,
    input  logic [TW-1:0]            h_fp_i,
    input  logic [TW-1:0]            h_sync_i,
    input  logic [TW-1:0]            h_bp_i,
    input  logic [TW-1:0]            v_active_i,
    input  logic [TW-1:0]            v_fp_i,
    input  logic [TW-1:0]            v_sync_i,
    input  logic [TW-1:0]            v_bp_i,
    input  logic                     hs_pol_i,
    input  logic                     vs_pol_i,
    output logic                     run,
    output logic                     h_last,
    output logic [PIXEL_WIDTH-1:0]   h_pix,
    output logic                     v_cell,
    output logic                     frame_phase,
    output logic [TW+1:0]            bar_w,
    output logic [1:0]               pattern,
    output logic [3*PIXEL_WIDTH-1:0] solid,
    output logic                     de_raw,
    output logic                     hs_raw,
    output logic                     vs_raw,
    output logic                     sof_raw
);

    localparam logic [TW+1:0] CNT_ZERO = {(TW+2){1'b0}};
    localparam logic [TW+1:0] CNT_ONE  = {{(TW+1){1'b0}}, 1'b1};

    // A zero-length region would stall the raster, so it is stretched to one.
    function automatic logic [TW+1:0] clamp(input logic [TW-1:0] val);
        logic [TW+1:0] res;
        if (val == {TW{1'b0}}) begin
            res = CNT_ONE;
        end else begin
            res = {2'b00, val};
        end
        return res;
    endfunction

    state_e                   state_r;
    state_e                   state_nxt_s;
    logic [TW+1:0]            h_cnt_r;
    logic [TW+1:0]            v_cnt_r;
    logic [3:0]               frame_cnt_r;
    logic [TW+1:0]            h_act_r;
    logic [TW+1:0]            h_fp_r;
    logic [TW+1:0]            h_sync_r;
    logic [TW+1:0]            h_bp_r;
    logic [TW+1:0]            v_act_r;
    logic [TW+1:0]            v_fp_r;
    logic [TW+1:0]            v_sync_r;
    logic [TW+1:0]            v_bp_r;
    logic                     hs_pol_r;
    logic                     vs_pol_r;
    logic [1:0]               pattern_r;
    logic [3*PIXEL_WIDTH-1:0] solid_r;

    logic [TW+1:0] h_sync_beg_s;
    logic [TW+1:0] h_sync_end_s;
    logic [TW+1:0] h_total_s;
    logic [TW+1:0] v_sync_beg_s;
    logic [TW+1:0] v_sync_end_s;
    logic [TW+1:0] v_total_s;
    logic [TW+1:0] bar_raw_s;
    logic          v_last_s;
    logic          frame_last_s;
    logic          load_s;
    logic          hs_act_s;
    logic          vs_act_s;

    assign h_sync_beg_s = h_act_r + h_fp_r;
    assign h_sync_end_s = h_sync_beg_s + h_sync_r;
    assign h_total_s    = h_sync_end_s + h_bp_r;
    assign v_sync_beg_s = v_act_r + v_fp_r;
    assign v_sync_end_s = v_sync_beg_s + v_sync_r;
    assign v_total_s    = v_sync_end_s + v_bp_r;

    assign run          = (state_r == ST_RUN);
    assign h_last       = (h_cnt_r == (h_total_s - CNT_ONE));
    assign v_last_s     = (v_cnt_r == (v_total_s - CNT_ONE));
    assign frame_last_s = run && h_last && v_last_s;
    assign load_s       = en_i && ((state_r == ST_IDLE) || frame_last_s);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state: start on request, stop only at a frame boundary.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (en_i) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (frame_last_s && !en_i) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Shadow registers: captured once per frame so mid-frame input changes wait.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_act_r   <= CNT_ZERO;
            h_fp_r    <= CNT_ZERO;
            h_sync_r  <= CNT_ZERO;
            h_bp_r    <= CNT_ZERO;
            v_act_r   <= CNT_ZERO;
            v_fp_r    <= CNT_ZERO;
            v_sync_r  <= CNT_ZERO;
            v_bp_r    <= CNT_ZERO;
            hs_pol_r  <= 1'b0;
            vs_pol_r  <= 1'b0;
            pattern_r <= 2'd0;
            solid_r   <= {(3*PIXEL_WIDTH){1'b0}};
        end else if (load_s) begin
            h_act_r   <= clamp(h_active_i);
            h_fp_r    <= clamp(h_fp_i);
            h_sync_r  <= clamp(h_sync_i);
            h_bp_r    <= clamp(h_bp_i);
            v_act_r   <= clamp(v_active_i);
            v_fp_r    <= clamp(v_fp_i);
            v_sync_r  <= clamp(v_sync_i);
            v_bp_r    <= clamp(v_bp_i);
            hs_pol_r  <= hs_pol_i;
            vs_pol_r  <= vs_pol_i;
            pattern_r <= pattern_i;
            solid_r   <= solid_i;
        end
    end

    // Raster counters; both sit at zero while idle so RUN always starts at the origin.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_cnt_r     <= CNT_ZERO;
            v_cnt_r     <= CNT_ZERO;
            frame_cnt_r <= 4'd0;
        end else if (!run) begin
            h_cnt_r <= CNT_ZERO;
            v_cnt_r <= CNT_ZERO;
        end else if (h_last) begin
            h_cnt_r <= CNT_ZERO;
            if (v_last_s) begin
                v_cnt_r <= CNT_ZERO;
                if (en_i) begin
                    frame_cnt_r <= frame_cnt_r + 4'd1;
                end
            end else begin
                v_cnt_r <= v_cnt_r + CNT_ONE;
            end
        end else begin
            h_cnt_r <= h_cnt_r + CNT_ONE;
        end
    end

    assign hs_act_s = run && (h_cnt_r >= h_sync_beg_s) && (h_cnt_r < h_sync_end_s);
    assign vs_act_s = run && (v_cnt_r >= v_sync_beg_s) && (v_cnt_r < v_sync_end_s);

    // Idle level follows the live polarity inputs; a running frame uses its shadowed copy.
    assign hs_raw  = run ? (hs_act_s ~^ hs_pol_r) : ~hs_pol_i;
    assign vs_raw  = run ? (vs_act_s ~^ vs_pol_r) : ~vs_pol_i;
    assign de_raw  = run && (h_cnt_r < h_act_r) && (v_cnt_r < v_act_r);
    assign sof_raw = run && (h_cnt_r == CNT_ZERO) && (v_cnt_r == CNT_ZERO);

    assign bar_raw_s   = h_act_r >> 3;
    assign bar_w       = (bar_raw_s == CNT_ZERO) ? CNT_ONE : bar_raw_s;
    assign h_pix       = h_cnt_r[PIXEL_WIDTH-1:0];
    assign v_cell      = v_cnt_r[4];
    assign frame_phase = frame_cnt_r[3];
    assign pattern     = pattern_r;
    assign solid       = solid_r;

endmodule

// File: rtl/video_pattern_gen.sv
// Test-pattern video source: raster timing from video_timing_counter plus the
// pattern generator and a single output register stage aligning all outputs.
module video_pattern_gen
    import video_pattern_gen_pkg::*;
#(
    parameter int PIXEL_WIDTH = 8,
    parameter int TW          = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en_i,
    input  logic [1:0]               pattern_i,
    input  logic [3*PIXEL_WIDTH-1:0] solid_i,
    input  logic [TW-1:0]            h_active_i,
    input  logic [TW-1:0]            h_fp_i,
    input  logic [TW-1:0]            h_sync_i,
    input  logic [TW-1:0]            h_bp_i,
    input  logic [TW-1:0]            v_active_i,
    input  logic [TW-1:0]            v_fp_i,
    input  logic [TW-1:0]            v_sync_i,
    input  logic [TW-1:0]            v_bp_i,
    input  logic                     hs_pol_i,
    input  logic                     vs_pol_i,
    output logic [3*PIXEL_WIDTH-1:0] do_o,
    output logic                     de_o,
    output logic                     hs_o,
    output logic                     vs_o,
    output logic                     sof_o
);

    localparam logic [TW+1:0]            CNT_ZERO = {(TW+2){1'b0}};
    localparam logic [TW+1:0]            CNT_ONE  = {{(TW+1){1'b0}}, 1'b1};
    localparam logic [3*PIXEL_WIDTH-1:0] PIX_ZERO = {(3*PIXEL_WIDTH){1'b0}};

    logic                     run_s;
    logic                     h_last_s;
    logic [PIXEL_WIDTH-1:0]   h_pix_s;
    logic                     v_cell_s;
    logic                     frame_phase_s;
    logic [TW+1:0]            bar_w_s;
    logic [1:0]               pattern_s;
    logic [3*PIXEL_WIDTH-1:0] solid_s;
    logic                     de_raw_s;
    logic                     hs_raw_s;
    logic                     vs_raw_s;
    logic                     sof_raw_s;
    logic [TW+1:0]            bar_pos_r;
    logic [2:0]               bar_idx_r;
    logic [2:0]               bar_rgb_s;
    logic                     check_white_s;
    logic [3*PIXEL_WIDTH-1:0] pix_s;

    video_timing_counter #(
        .PIXEL_WIDTH(PIXEL_WIDTH),
        .TW         (TW)
    ) u_timing (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (en_i),
        .pattern_i  (pattern_i),
        .solid_i    (solid_i),
        .h_active_i (h_active_i),
        .h_fp_i     (h_fp_i),
        .h_sync_i   (h_sync_i),
        .h_bp_i     (h_bp_i),
        .v_active_i (v_active_i),
        .v_fp_i     (v_fp_i),
        .v_sync_i   (v_sync_i),
        .v_bp_i     (v_bp_i),
        .hs_pol_i   (hs_pol_i),
        .vs_pol_i   (vs_pol_i),
        .run        (run_s),
        .h_last     (h_last_s),
        .h_pix      (h_pix_s),
        .v_cell     (v_cell_s),
        .frame_phase(frame_phase_s),
        .bar_w      (bar_w_s),
        .pattern    (pattern_s),
        .solid      (solid_s),
        .de_raw     (de_raw_s),
        .hs_raw     (hs_raw_s),
        .vs_raw     (vs_raw_s),
        .sof_raw    (sof_raw_s)
    );

    // Bar tracker mirrors h_cnt: restarts every line, index saturates on the last bar.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bar_pos_r <= CNT_ZERO;
            bar_idx_r <= 3'd0;
        end else if (!run_s || h_last_s) begin
            bar_pos_r <= CNT_ZERO;
            bar_idx_r <= 3'd0;
        end else if (bar_pos_r == (bar_w_s - CNT_ONE)) begin
            bar_pos_r <= CNT_ZERO;
            bar_idx_r <= bar_next(bar_idx_r);
        end else begin
            bar_pos_r <= bar_pos_r + CNT_ONE;
        end
    end

    assign bar_rgb_s     = bar_rgb(bar_idx_r);
    assign check_white_s = h_pix_s[4] ^ v_cell_s ^ frame_phase_s;

    // Pattern select; components pack as {B, G, R} from MSB to LSB.
    always_comb begin
        pix_s = PIX_ZERO;
        case (pattern_e'(pattern_s))
            PAT_BARS:  pix_s = {{PIXEL_WIDTH{bar_rgb_s[2]}},
                                {PIXEL_WIDTH{bar_rgb_s[1]}},
                                {PIXEL_WIDTH{bar_rgb_s[0]}}};
            PAT_GRAD:  pix_s = {3{h_pix_s}};
            PAT_SOLID: pix_s = solid_s;
            PAT_CHECK: pix_s = {(3*PIXEL_WIDTH){check_white_s}};
            default:   pix_s = PIX_ZERO;
        endcase
    end

    // Output stage: one register for every output so they stay mutually aligned.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            do_o  <= PIX_ZERO;
            de_o  <= 1'b0;
            hs_o  <= 1'b0;
            vs_o  <= 1'b0;
            sof_o <= 1'b0;
        end else begin
            do_o  <= de_raw_s ? pix_s : PIX_ZERO;
            de_o  <= de_raw_s;
            hs_o  <= hs_raw_s;
            vs_o  <= vs_raw_s;
            sof_o <= sof_raw_s;
        end
    end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed self-checking bench for video_pattern_gen: timing, bars, polarity,
// shadowing, stop/reset and zero-field clamping.
module tb_video_pattern_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_i;
    logic [1:0]  pattern_i;
    logic [23:0] solid_i;
    logic [11:0] h_active_i, h_fp_i, h_sync_i, h_bp_i;
    logic [11:0] v_active_i, v_fp_i, v_sync_i, v_bp_i;
    logic        hs_pol_i, vs_pol_i;
    logic [23:0] do_o;
    logic        de_o, hs_o, vs_o, sof_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    video_pattern_gen #(.PIXEL_WIDTH(8), .TW(12)) dut (
        .clk(clk), .rst_n(rst_n), .en_i(en_i), .pattern_i(pattern_i), .solid_i(solid_i),
        .h_active_i(h_active_i), .h_fp_i(h_fp_i), .h_sync_i(h_sync_i), .h_bp_i(h_bp_i),
        .v_active_i(v_active_i), .v_fp_i(v_fp_i), .v_sync_i(v_sync_i), .v_bp_i(v_bp_i),
        .hs_pol_i(hs_pol_i), .vs_pol_i(vs_pol_i),
        .do_o(do_o), .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o), .sof_o(sof_o)
    );

    task automatic set_common(input logic [1:0] pat);
        h_active_i = 12'd16; h_fp_i = 12'd2; h_sync_i = 12'd3; h_bp_i = 12'd4;
        v_active_i = 12'd4;  v_fp_i = 12'd1; v_sync_i = 12'd2; v_bp_i = 12'd1;
        hs_pol_i = 1'b1; vs_pol_i = 1'b1; pattern_i = pat; solid_i = 24'h000000;
    endtask

    task automatic do_reset();
        en_i = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Bounded wait; n is the number of negedges until de_o was first seen high.
    task automatic wait_first_de(output bit found, output int n);
        found = 1'b0;
        n = 0;
        while (!found && n < 64) begin
            @(negedge clk);
            n++;
            if (de_o === 1'b1) found = 1'b1;
        end
    endtask

    task automatic test_reset();
        set_common(2'd0);
        en_i = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({do_o, de_o, hs_o, vs_o, sof_o} !== 28'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", {do_o, de_o, hs_o, vs_o, sof_o});
        end
        en_i = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({de_o, hs_o, vs_o, sof_o} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_idle: got %b expected 0000", {de_o, hs_o, vs_o, sof_o});
        end
    endtask

    task automatic test_timing();
        bit   found;
        int   n, h, v, f, bad;
        int   de_c[3], hs_c[3], vs_c[3], sof_c[3];
        logic e_de, e_hs, e_vs, e_sof;
        set_common(2'd1);
        do_reset();
        en_i = 1'b1;
        wait_first_de(found, n);
        checks++;
        if (!found || n != 2) begin
            errors++;
            $display("FAIL timing_first_de: got found=%0d after %0d cycles expected 2", found, n);
        end
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            de_c[i] = 0; hs_c[i] = 0; vs_c[i] = 0; sof_c[i] = 0;
        end
        for (int s = 0; s < 600; s++) begin
            if (s > 0) @(negedge clk);
            f = s / 200;
            h = s % 25;
            v = (s % 200) / 25;
            de_c[f] += int'(de_o); hs_c[f] += int'(hs_o);
            vs_c[f] += int'(vs_o); sof_c[f] += int'(sof_o);
            e_de  = (h < 16) && (v < 4);
            e_hs  = (h >= 18) && (h < 21);
            e_vs  = (v >= 5) && (v < 7);
            e_sof = (s % 200) == 0;
            if ({de_o, hs_o, vs_o, sof_o} !== {e_de, e_hs, e_vs, e_sof}) bad++;
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (de_c[i] != 64) begin errors++; $display("FAIL timing_de_count f%0d: got %0d expected 64", i, de_c[i]); end
            checks++;
            if (hs_c[i] != 24) begin errors++; $display("FAIL timing_hs_count f%0d: got %0d expected 24", i, hs_c[i]); end
            checks++;
            if (vs_c[i] != 50) begin errors++; $display("FAIL timing_vs_count f%0d: got %0d expected 50", i, vs_c[i]); end
            checks++;
            if (sof_c[i] != 1) begin errors++; $display("FAIL timing_sof_count f%0d: got %0d expected 1", i, sof_c[i]); end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL timing_positions: got %0d misplaced cycles expected 0", bad);
        end
    endtask

    task automatic test_bars();
        bit          found;
        int          n;
        logic [23:0] exp_bar [8];
        logic [23:0] exp;
        exp_bar = '{24'hFFFFFF, 24'h00FFFF, 24'hFFFF00, 24'h00FF00,
                    24'hFF00FF, 24'h0000FF, 24'hFF0000, 24'h000000};
        set_common(2'd0);
        do_reset();
        en_i = 1'b1;
        wait_first_de(found, n);
        checks++;
        if (!found) begin errors++; $display("FAIL bars_start: got no de_o expected de_o"); end
        for (int s = 0; s < 18; s++) begin
            if (s > 0) @(negedge clk);
            exp = (s < 16) ? exp_bar[s / 2] : 24'h000000;
            checks++;
            if (do_o !== exp) begin
                errors++;
                $display("FAIL bars_px%0d: got %h expected %h", s, do_o, exp);
            end
        end
    endtask

    task automatic test_polarity_solid();
        bit          found;
        int          n, h, v, bad, hs_low, vs_low;
        logic [23:0] exp;
        set_common(2'd2);
        hs_pol_i = 1'b0; vs_pol_i = 1'b0; solid_i = 24'h123456;
        do_reset();
        checks++;
        if ({hs_o, vs_o} !== 2'b11) begin
            errors++;
            $display("FAIL pol_idle: got hs/vs %b expected 11", {hs_o, vs_o});
        end
        en_i = 1'b1;
        wait_first_de(found, n);
        checks++;
        if (do_o !== 24'h123456) begin
            errors++;
            $display("FAIL solid_first: got %h expected 123456", do_o);
        end
        bad = 0; hs_low = 0; vs_low = 0;
        for (int s = 0; s < 200; s++) begin
            if (s > 0) @(negedge clk);
            h = s % 25;
            v = s / 25;
            exp = ((h < 16) && (v < 4)) ? 24'h123456 : 24'h000000;
            if (do_o !== exp) bad++;
            if (hs_o === 1'b0) hs_low++;
            if (vs_o === 1'b0) vs_low++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL solid_data: got %0d bad pixels expected 0", bad); end
        checks++;
        if (hs_low != 24) begin errors++; $display("FAIL pol_hs_low: got %0d expected 24", hs_low); end
        checks++;
        if (vs_low != 50) begin errors++; $display("FAIL pol_vs_low: got %0d expected 50", vs_low); end
    endtask

    task automatic test_shadowing();
        bit          found;
        int          n, de0, de1;
        logic        de_h [336];
        logic        sof_h [336];
        logic [23:0] do_h [336];
        set_common(2'd1);
        do_reset();
        en_i = 1'b1;
        wait_first_de(found, n);
        for (int s = 0; s < 336; s++) begin
            if (s > 0) @(negedge clk);
            de_h[s] = de_o; sof_h[s] = sof_o; do_h[s] = do_o;
            if (s == 1) h_active_i = 12'd8;
        end
        de0 = 0; de1 = 0;
        for (int s = 0; s < 336; s++) begin
            if (s < 200) de0 += int'(de_h[s]);
            else         de1 += int'(de_h[s]);
        end
        checks++;
        if (de0 != 64) begin errors++; $display("FAIL shadow_cur_frame: got %0d de expected 64", de0); end
        checks++;
        if (de1 != 32) begin errors++; $display("FAIL shadow_next_frame: got %0d de expected 32", de1); end
        checks++;
        if (do_h[5] !== 24'h050505) begin errors++; $display("FAIL grad_px5: got %h expected 050505", do_h[5]); end
        checks++;
        if ({sof_h[200], de_h[207], de_h[208], de_h[217]} !== 4'b1101) begin
            errors++;
            $display("FAIL shadow_edges: got %b expected 1101",
                     {sof_h[200], de_h[207], de_h[208], de_h[217]});
        end
        checks++;
        if (do_h[207] !== 24'h070707) begin errors++; $display("FAIL grad_px7_f1: got %h expected 070707", do_h[207]); end
    endtask

    task automatic test_stop_reset();
        bit found;
        int n, de0, de_after, sof_after;
        set_common(2'd2);
        solid_i = 24'hA5C33C;
        do_reset();
        en_i = 1'b1;
        wait_first_de(found, n);
        de0 = 0; de_after = 0; sof_after = 0;
        for (int s = 0; s < 300; s++) begin
            if (s > 0) @(negedge clk);
            if (s < 200) de0 += int'(de_o);
            else begin
                de_after += int'(de_o);
                sof_after += int'(sof_o);
            end
            if (s == 50) en_i = 1'b0;
        end
        checks++;
        if (de0 != 64) begin errors++; $display("FAIL stop_completes: got %0d de expected 64", de0); end
        checks++;
        if (de_after + sof_after != 0 || hs_o !== 1'b0) begin
            errors++;
            $display("FAIL stop_idle: got de=%0d sof=%0d hs=%b expected 0 0 0", de_after, sof_after, hs_o);
        end
        en_i = 1'b1;
        wait_first_de(found, n);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({do_o, de_o, hs_o, vs_o, sof_o} !== 28'd0) begin
            errors++;
            $display("FAIL rst_midline: got %h expected 0", {do_o, de_o, hs_o, vs_o, sof_o});
        end
        rst_n = 1'b1;
        wait_first_de(found, n);
        checks++;
        if (!found || n != 2 || sof_o !== 1'b1 || do_o !== 24'hA5C33C) begin
            errors++;
            $display("FAIL rst_restart: got found=%0d n=%0d sof=%b do=%h expected 1 2 1 a5c33c",
                     found, n, sof_o, do_o);
        end
    endtask

    task automatic test_clamp();
        bit   found;
        int   n, h, v, bad, de_c;
        logic e_de, e_hs;
        set_common(2'd2);
        solid_i = 24'h0F0F0F;
        h_active_i = 12'd0; h_fp_i = 12'd0; h_sync_i = 12'd0; h_bp_i = 12'd0;
        do_reset();
        en_i = 1'b1;
        wait_first_de(found, n);
        checks++;
        if (!found) begin errors++; $display("FAIL clamp_start: got no de_o expected de_o"); end
        bad = 0; de_c = 0;
        for (int s = 0; s < 33; s++) begin
            if (s > 0) @(negedge clk);
            h = s % 4;
            v = (s % 32) / 4;
            e_de = (h == 0) && (v < 4);
            e_hs = (h == 2);
            if (s < 32) de_c += int'(de_o);
            if ({de_o, hs_o} !== {e_de, e_hs}) bad++;
        end
        checks++;
        if (de_c != 4) begin errors++; $display("FAIL clamp_de_count: got %0d expected 4", de_c); end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL clamp_positions: got %0d bad cycles expected 0", bad); end
        checks++;
        if (sof_o !== 1'b1) begin errors++; $display("FAIL clamp_next_frame: got sof %b expected 1", sof_o); end
    endtask

    initial begin
        rst_n = 1'b0;
        en_i  = 1'b0;
        set_common(2'd0);
        test_reset();
        test_timing();
        test_bars();
        test_polarity_solid();
        test_shadowing();
        test_stop_reset();
        test_clamp();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
